pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
// - Parametrised inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB) with valid/ready handshake.
// - Supports stall (back-pressure), flush (squash), bubble insertion and optional 2-entry skid buffer.
// - Payload split in two fields:
//   - CTRL: regWrite, memRead, memWrite, ... ; forced to 0 for every invalid entry, so a bubble
//     never commits.
//   - DATA: imm, rs1Data, rs2Data, register ids; passed through, not cleared.
// PARAMETERS
// - DATA_W  32  width of data payload (imm/operands/reg ids concatenated)
// - CTRL_W  8   width of control payload (zeroed on bubble/flush/reset)
// - SKID    1   1 = 2-entry skid buffer, in_ready registered; 0 = single entry, in_ready combinational
// PORTS
// - clk        in   1       clock, rising edge
// - resetn     in   1       synchronous reset, active-low
// - flush      in   1       squash all held entries and the beat offered this cycle
// - in_valid   in   1       upstream beat valid
// - in_ready   out  1       stage can accept a beat
// - in_data    in   DATA_W  upstream data payload
// - in_ctrl    in   CTRL_W  upstream control payload
// - out_valid  out  1       downstream beat valid
// - out_ready  in   1       downstream accepts beat (0 = stall)
// - out_data   out  DATA_W  payload of head entry
// - out_ctrl   out  CTRL_W  control of head entry; 0 whenever out_valid=0
// - occupancy  out  2       entries held (0..1 if SKID=0, 0..2 if SKID=1)
// BEHAVIOUR
// - Reset (resetn=0 at a clk edge): out_valid=0, out_data=0, out_ctrl=0, occupancy=0, skid cleared.
//   - in_ready=0 while resetn=0.
//   - in_ready=1 from the first cycle after reset deassertion.
// - Transfers:
//   - Accept = in_valid & in_ready; emit = out_valid & out_ready.
//   - Latency: accepted beat appears on out_* the next cycle when the stage was empty or emitting.
// - Ordering: strict FIFO; skid entry is always younger than the head entry.
// - SKID=0:
//   - in_ready = !out_valid | out_ready.
//   - Head loads on accept.
//   - On emit without accept: out_valid<=0 and out_ctrl<=0.
// - SKID=1:
//   - in_ready = !skid_valid (registered; no combinational ready path).
//   - head empty or emitting: head <= skid if skid_valid, else in_*, if accept.
//   - head full and not emitting, with accept: beat goes to skid; in_ready drops next cycle.
//   - emit and accept while skid full cannot occur (in_ready=0).
//   - emit while skid full: skid -> head, skid empties, in_ready=1 next cycle.
// - Stall: out_ready=0 holds out_data/out_ctrl/out_valid stable until emit; never drops a valid beat.
// - Flush (sync, priority over accept/emit):
//   - Next cycle: out_valid=0, out_ctrl=0, skid invalid, occupancy=0.
//   - A beat accepted in the flush cycle is discarded.
//   - out_data may retain stale value.
//   - in_ready not gated by flush.
// - Bubble: any cycle with out_valid=0 presents out_ctrl=0 (NOP to MEM/WB).
// - Reset wins over flush; reset mid-stall drops all held entries.
// - occupancy = head_valid + skid_valid, updated same edge as valids.
// TESTING
// - Reset:
//   - Hold resetn=0 2 cycles with in_valid=1, in_ctrl=8'hFF -> out_valid=0, out_ctrl=0, in_ready=0.
//   - After release, in_ready=1.
// - Streaming:
//   - out_ready=1, 4 beats data 0x11,0x22,0x33,0x44 back-to-back.
//   - -> same order on out_data, 1-cycle latency, no gaps, occupancy<=1.
// - Stall (SKID=1):
//   - out_ready=0, send 0xA1, 0xA2, 0xA3 -> 0xA1 at head, 0xA2 in skid, occupancy=2, in_ready=0.
//   - 0xA3 held upstream.
//   - out_ready=1 -> 0xA1, 0xA2, 0xA3 in order with no loss.
// - Flush:
//   - Occupancy=2, then flush=1 with in_valid=1 data 0xBB.
//   - -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0xBB never appears.
// - Bubble:
//   - in_valid=0 for 1 cycle between beats with ctrl 8'h05.
//   - -> out_ctrl=0 in the gap cycle, out_valid=0.
// - SKID=0:
//   - out_ready toggled 1,0,1 with continuous in_valid.
//   - -> in_ready follows out_ready whenever head valid; no duplication.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream beat, downstream beat, flush and fill level.
// The slave modport is the pipeline register itself; master is whoever drives it.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    modport master (
        output flush, in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occupancy
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush and optional skid entry.
// Control payload of any non-valid entry reads as zero so a bubble never commits.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic            clk,
    input  logic            resetn,
    pipe_stage_reg_if.slave bus
);
    logic              head_valid_reg, head_valid_next;
    logic [DATA_W-1:0] head_data_reg,  head_data_next;
    logic [CTRL_W-1:0] head_ctrl_reg,  head_ctrl_next;
    logic              skid_valid_reg, skid_valid_next;
    logic [DATA_W-1:0] skid_data_reg,  skid_data_next;
    logic [CTRL_W-1:0] skid_ctrl_reg,  skid_ctrl_next;
    logic              ready_reg,      ready_next;

    logic in_ready_int;
    logic accept;
    logic emit;

    // With a skid entry the upstream ready is purely registered; without one it
    // must look through to out_ready so a full head can still stream.
    assign in_ready_int = resetn & ((SKID != 0) ? ready_reg
                                                : (~head_valid_reg | bus.out_ready));
    assign accept = bus.in_valid & in_ready_int;
    assign emit   = head_valid_reg & bus.out_ready;

    always_comb begin
        head_valid_next = head_valid_reg;
        head_data_next  = head_data_reg;
        head_ctrl_next  = head_ctrl_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_ctrl_next  = skid_ctrl_reg;
        ready_next      = ready_reg;

        if (bus.flush) begin
            head_valid_next = 1'b0;
            head_ctrl_next  = '0;
            skid_valid_next = 1'b0;
            skid_ctrl_next  = '0;
            ready_next      = 1'b1;
        end else if (!head_valid_reg || emit) begin
            // Head slot frees up: the older skid beat has priority over new input.
            if (skid_valid_reg) begin
                head_valid_next = 1'b1;
                head_data_next  = skid_data_reg;
                head_ctrl_next  = skid_ctrl_reg;
                skid_valid_next = 1'b0;
                skid_ctrl_next  = '0;
                ready_next      = 1'b1;
            end else if (accept) begin
                head_valid_next = 1'b1;
                head_data_next  = bus.in_data;
                head_ctrl_next  = bus.in_ctrl;
            end else begin
                head_valid_next = 1'b0;
                head_ctrl_next  = '0;
            end
        end else if (accept && (SKID != 0)) begin
            skid_valid_next = 1'b1;
            skid_data_next  = bus.in_data;
            skid_ctrl_next  = bus.in_ctrl;
            ready_next      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_valid_reg <= 1'b0;
            head_data_reg  <= '0;
            head_ctrl_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_ctrl_reg  <= '0;
            ready_reg      <= 1'b1;
        end else begin
            head_valid_reg <= head_valid_next;
            head_data_reg  <= head_data_next;
            head_ctrl_reg  <= head_ctrl_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_ctrl_reg  <= skid_ctrl_next;
            ready_reg      <= ready_next;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = head_valid_reg;
    assign bus.out_data  = head_data_reg;
    assign bus.occupancy = {1'b0, head_valid_reg} + {1'b0, skid_valid_reg};

    // Belt-and-braces masking of control by valid on the output side.
    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
            assign bus.out_ctrl[gi] = head_ctrl_reg[gi] & head_valid_reg;
        end
    endgenerate
endmodule
